bk_word_sequencer: RTL

// - Multi-word add sequencer around the 6-bit Brent-Kung slice: loads NWORDS operand word pairs (LSW first),

---
 rtl/bk_seq_pkg.sv | 14 +
 rtl/bk_word_buf.sv | 31 +++
 rtl/bk_word_sequencer.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/bk_seq_pkg.sv
// rtl/bk_seq_pkg.sv - shared defaults and state encoding for the multi-word add sequencer
package bk_seq_pkg;

    localparam int BK_WORD_W = 6;
    localparam int BK_NWORDS = 4;
    localparam int BK_CNT_W  = $clog2(BK_NWORDS);

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_ADD,
        ST_DRAIN
    } state_e;

endpackage

// File: rtl/bk_word_buf.sv
// rtl/bk_word_buf.sv - NWORDS x WORD_W register file, one write port, one combinational read port
module bk_word_buf #(
    parameter int WORD_W = 6,
    parameter int NWORDS = 4,
    parameter int AW     = $clog2(NWORDS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem_q [NWORDS];

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            for (int i = 0; i < NWORDS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/bk_word_sequencer.sv
// rtl/bk_word_sequencer.sv - loads word pairs, chains them through the adder slice, streams the sum out
// Optional subtract mode (A-B via inverted B and forced carry-in) enabled by defining BK_SEQ_SUB_EN.
module bk_word_sequencer
    import bk_seq_pkg::*;
#(
    parameter int WORD_W = BK_WORD_W,
    parameter int NWORDS = BK_NWORDS
) (
    input  logic              clk,
    input  logic              rst,
`ifdef BK_SEQ_SUB_EN
    input  logic              in_sub,
`endif
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_a,
    input  logic [WORD_W-1:0] in_b,
    input  logic              in_cin,
    input  logic              in_last,
    output logic [WORD_W-1:0] adder_a,
    output logic [WORD_W-1:0] adder_b,
    output logic              adder_cin,
    input  logic [WORD_W-1:0] adder_sum,
    input  logic              adder_cout,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_sum,
    output logic              out_last,
    output logic              out_carry,
    output logic              busy
);

    localparam int CNT_W = $clog2(NWORDS);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NWORDS - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              carry_q, carry_d;
    logic              ld_we, sum_we, drain_done;
    logic              start_carry, sub_eff;
    logic [WORD_W-1:0] a_rd, b_rd, sum_rd;

`ifdef BK_SEQ_SUB_EN
    logic sub_q, sub_d;
    assign sub_eff     = sub_q;
    assign start_carry = in_sub ? 1'b1 : in_cin;
    assign sub_d       = (state_q == ST_LOAD && in_valid && cnt_q == '0) ? in_sub : sub_q;
`else
    assign sub_eff     = 1'b0;
    assign start_carry = in_cin;
`endif

    // Buffers are wiped at the end of each drain so short operands see zero-filled upper words.
    bk_word_buf #(.WORD_W(WORD_W), .NWORDS(NWORDS)) u_buf_a (
        .clk(clk), .rst(rst), .clr(drain_done), .we(ld_we), .waddr(cnt_q),
        .wdata(in_a), .raddr(cnt_q), .rdata(a_rd)
    );

    bk_word_buf #(.WORD_W(WORD_W), .NWORDS(NWORDS)) u_buf_b (
        .clk(clk), .rst(rst), .clr(drain_done), .we(ld_we), .waddr(cnt_q),
        .wdata(in_b), .raddr(cnt_q), .rdata(b_rd)
    );

    bk_word_buf #(.WORD_W(WORD_W), .NWORDS(NWORDS)) u_buf_sum (
        .clk(clk), .rst(rst), .clr(drain_done), .we(sum_we), .waddr(cnt_q),
        .wdata(adder_sum), .raddr(cnt_q), .rdata(sum_rd)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        carry_d    = carry_q;
        ld_we      = 1'b0;
        sum_we     = 1'b0;
        drain_done = 1'b0;
        in_ready   = 1'b0;
        adder_a    = '0;
        adder_b    = '0;
        adder_cin  = 1'b0;
        out_valid  = 1'b0;
        out_sum    = '0;
        out_last   = 1'b0;
        out_carry  = 1'b0;
        case (state_q)
            ST_LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    ld_we = 1'b1;
                    if (cnt_q == '0) begin
                        carry_d = start_carry;
                    end
                    if (in_last || cnt_q == LAST_IDX) begin
                        state_d = ST_ADD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_ADD: begin
                adder_a   = a_rd;
                adder_b   = sub_eff ? ~b_rd : b_rd;
                adder_cin = carry_q;
                sum_we    = 1'b1;
                carry_d   = adder_cout;
                if (cnt_q == LAST_IDX) begin
                    state_d = ST_DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DRAIN: begin
                out_valid = 1'b1;
                out_sum   = sum_rd;
                out_last  = (cnt_q == LAST_IDX);
                out_carry = out_last & carry_q;
                if (out_ready) begin
                    if (out_last) begin
                        state_d    = ST_LOAD;
                        cnt_d      = '0;
                        drain_done = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_LOAD;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_LOAD;
            cnt_q   <= '0;
            carry_q <= 1'b0;
`ifdef BK_SEQ_SUB_EN
            sub_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
`ifdef BK_SEQ_SUB_EN
            sub_q   <= sub_d;
`endif
        end
    end

    assign busy = (state_q != ST_LOAD) || (cnt_q != '0);

endmodule
